// File: rtl/adder_share_arb_pkg.sv
// Shared definitions for the adder_share_arb block: default sizes and the bit
// positions of the C/O/Z flags inside the registered result.
package adder_share_arb_pkg;

  localparam int DEFAULT_W    = 8;
  localparam int DEFAULT_NREQ = 2;

  // Flag vector layout, also used by consumers that unpack a flags word.
  localparam int FLAG_C = 0;
  localparam int FLAG_O = 1;
  localparam int FLAG_Z = 2;
  localparam int NFLAGS = 3;

endpackage

// File: rtl/adder_share_arb_if.sv
// Request/result bundle between the requesting units and the shared adder.
interface adder_share_arb_if #(
  parameter int W    = 8,
  parameter int NREQ = 2
);
  localparam int IDW = $clog2(NREQ);

  // Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // a result transfers on a cycle where out_valid & out_ready. Payloads are held
  // stable by the sender while valid is high and ready is low.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_sub;
  logic              out_valid;
  logic              out_ready;
  logic [IDW-1:0]    out_id;
  logic [W-1:0]      out_s;
  logic              out_c;
  logic              out_o;
  logic              out_z;

  modport slave (
    input  req_valid, req_x, req_y, req_sub, out_ready,
    output req_ready, out_valid, out_id, out_s, out_c, out_o, out_z
  );

  modport master (
    output req_valid, req_x, req_y, req_sub, out_ready,
    input  req_ready, out_valid, out_id, out_s, out_c, out_o, out_z
  );

endinterface

// File: rtl/adder_share_arb_rr_arbiter.sv
// Round-robin grant: first asserted request at or above ptr, wrapping to 0.
module adder_share_arb_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int             pos;
  logic [IDW-1:0] p;
  logic           found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    pos     = 0;
    p       = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (int'(ptr_i) + k) % NREQ;
      p   = IDW'(pos);
      if (en_i && !found && req_i[p]) begin
        found      = 1'b1;
        grant_o[p] = 1'b1;
        idx_o      = p;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/adder_share_arb.sv
// One add/sub datapath shared by NREQ requesters: round-robin arbitration,
// single registered result slot carrying flags and the winning requester id.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int W    = DEFAULT_W,
  parameter int NREQ = DEFAULT_NREQ,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  adder_share_arb_if.slave  bus,
  output logic [IDW-1:0]    ptr_o
);

  logic              free;
  logic              arb_en;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gidx;
  logic              accept;

  logic [W-1:0]      x_sel;
  logic [W-1:0]      y_sel;
  logic              sub_sel;
  logic [W-1:0]      t;
  logic [W:0]        sum;
  logic              ovf;

  logic              out_valid_q, out_valid_d;
  logic [IDW-1:0]    out_id_q,    out_id_d;
  logic [W-1:0]      s_q,         s_d;
  logic [NFLAGS-1:0] flags_q,     flags_d;
  logic [IDW-1:0]    ptr_q,       ptr_d;

  // Reset also blocks grants so nothing is accepted while the slot is being cleared.
  assign free   = ~out_valid_q | bus.out_ready;
  assign arb_en = free & ~rst;

  adder_share_arb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (accept)
  );

  assign bus.req_ready = grant;

  always_comb begin
    x_sel   = '0;
    y_sel   = '0;
    sub_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IDW'(i)) begin
        x_sel   = bus.req_x[i*W +: W];
        y_sel   = bus.req_y[i*W +: W];
        sub_sel = bus.req_sub[i];
      end
    end
  end

  // Subtract as x + ~y + 1, so carry out means "no borrow".
  always_comb begin
    t   = y_sel ^ {W{sub_sel}};
    sum = {1'b0, x_sel} + {1'b0, t} + {{W{1'b0}}, sub_sel};
    ovf = ~(x_sel[W-1] ^ t[W-1]) & (sum[W-1] ^ x_sel[W-1]);
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    s_d         = s_q;
    flags_d     = flags_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d     = 1'b1;
      out_id_d        = gidx;
      s_d             = sum[W-1:0];
      flags_d[FLAG_C] = sum[W];
      flags_d[FLAG_O] = ovf;
      flags_d[FLAG_Z] = ~|sum[W-1:0];
      ptr_d           = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      s_q         <= '0;
      flags_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      s_q         <= s_d;
      flags_q     <= flags_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_s     = s_q;
  assign bus.out_c     = flags_q[FLAG_C];
  assign bus.out_o     = flags_q[FLAG_O];
  assign bus.out_z     = flags_q[FLAG_Z];
  assign ptr_o         = ptr_q;

endmodule
